// File: rtl/rsa_pkg.sv
// Shared types and default register map for the RSA UART wrapper.
// Holds FSM state enum, byte I/O phase enum and bus constants.
package rsa_pkg;

  typedef enum logic [2:0] {
    S_GET_N,
    S_GET_E,
    S_GET_DATA,
    S_WAIT_CALC,
    S_SEND_DATA
  } state_t;

  typedef enum logic {
    PH_STATUS,
    PH_XFER
  } phase_t;

  localparam int RX_BASE_D     = 0;
  localparam int TX_BASE_D     = 4;
  localparam int STATUS_BASE_D = 8;
  localparam int RX_OK_BIT_D   = 7;
  localparam int TX_OK_BIT_D   = 6;

endpackage

// File: rtl/rsa_avm_byte_io.sv
// Avalon-MM byte mover: polls UART status, then reads or writes one byte.
// Ports: req/tx/tx_byte in, done/rx_byte out, avm_* master bus.
module rsa_avm_byte_io
  import rsa_pkg::*;
#(
  parameter int RX_BASE     = RX_BASE_D,
  parameter int TX_BASE     = TX_BASE_D,
  parameter int STATUS_BASE = STATUS_BASE_D,
  parameter int RX_OK_BIT   = RX_OK_BIT_D,
  parameter int TX_OK_BIT   = TX_OK_BIT_D
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        req,
  input  logic        tx,
  input  logic [7:0]  tx_byte,
  output logic        done,
  output logic [7:0]  rx_byte,
  output logic [4:0]  avm_address,
  output logic        avm_read,
  input  logic [31:0] avm_readdata,
  output logic        avm_write,
  output logic [31:0] avm_writedata,
  input  logic        avm_waitrequest
);

  localparam logic [4:0] A_RX = 5'(RX_BASE);
  localparam logic [4:0] A_TX = 5'(TX_BASE);
  localparam logic [4:0] A_ST = 5'(STATUS_BASE);

  phase_t     phase;
  logic [7:0] wd;
  logic       busy;
  logic       hit;
  logic       ok;
  logic       unused_rd;

  assign busy = avm_read | avm_write;
  assign hit  = busy & ~avm_waitrequest;
  assign ok   = tx ? avm_readdata[TX_OK_BIT]
                   : avm_readdata[RX_OK_BIT];
  assign done = hit & (phase == PH_XFER);
  assign rx_byte = avm_readdata[7:0];
  assign avm_writedata = {24'd0, wd};
  assign unused_rd = ^avm_readdata[31:8];

  // req reflects the FSM's next state, so a finished
  // transfer chains straight into the next status poll.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      phase       <= PH_STATUS;
      avm_read    <= 1'b0;
      avm_write   <= 1'b0;
      avm_address <= A_ST;
      wd          <= '0;
    end else if (!busy || done) begin
      phase       <= PH_STATUS;
      avm_read    <= req;
      avm_write   <= 1'b0;
      avm_address <= A_ST;
    end else if (hit && ok) begin
      phase       <= PH_XFER;
      avm_read    <= ~tx;
      avm_write   <= tx;
      avm_address <= tx ? A_TX : A_RX;
      wd          <= tx_byte;
    end
    // stalled or bit clear: hold, which re-polls next cycle
  end

endmodule

// File: rtl/rsa_uart_wrapper.sv
// Loads n, e and ciphertext blocks over a UART, runs the RSA core,
// and returns 31 result bytes. Ports: Avalon-MM master + core I/F.
module rsa_uart_wrapper
  import rsa_pkg::*;
#(
  parameter int RX_BASE     = RX_BASE_D,
  parameter int TX_BASE     = TX_BASE_D,
  parameter int STATUS_BASE = STATUS_BASE_D,
  parameter int RX_OK_BIT   = RX_OK_BIT_D,
  parameter int TX_OK_BIT   = TX_OK_BIT_D
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  output logic [4:0]   avm_address,
  output logic         avm_read,
  input  logic [31:0]  avm_readdata,
  output logic         avm_write,
  output logic [31:0]  avm_writedata,
  input  logic         avm_waitrequest,
  output logic         o_core_start,
  output logic [255:0] o_core_a,
  output logic [255:0] o_core_e,
  output logic [255:0] o_core_n,
  input  logic [255:0] i_core_result,
  input  logic         i_core_finished
);

  state_t       state, state_next;
  logic [4:0]   cnt;
  logic [255:0] n, e, a;
  logic [247:0] res;
  logic         start;
  logic         req, tx, done, last;
  logic [7:0]   rx_byte;
  logic         unused_res;

  assign o_core_start = start;
  assign o_core_a     = a;
  assign o_core_e     = e;
  assign o_core_n     = n;
  assign unused_res   = ^i_core_result[255:248];

  assign tx   = (state == S_SEND_DATA);
  assign last = done & (tx ? (cnt == 5'd30) : (cnt == 5'd31));
  assign req  = (state_next != S_WAIT_CALC);

  rsa_avm_byte_io #(
    .RX_BASE     (RX_BASE),
    .TX_BASE     (TX_BASE),
    .STATUS_BASE (STATUS_BASE),
    .RX_OK_BIT   (RX_OK_BIT),
    .TX_OK_BIT   (TX_OK_BIT)
  ) u_io (
    .i_clk           (i_clk),
    .i_rst_n         (i_rst_n),
    .req             (req),
    .tx              (tx),
    .tx_byte         (res[247:240]),
    .done            (done),
    .rx_byte         (rx_byte),
    .avm_address     (avm_address),
    .avm_read        (avm_read),
    .avm_readdata    (avm_readdata),
    .avm_write       (avm_write),
    .avm_writedata   (avm_writedata),
    .avm_waitrequest (avm_waitrequest)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state <= S_GET_N;
    else          state <= state_next;
  end

  always_comb begin
    state_next = state;
    unique case (state)
      S_GET_N:     if (last) state_next = S_GET_E;
      S_GET_E:     if (last) state_next = S_GET_DATA;
      S_GET_DATA:  if (last) state_next = S_WAIT_CALC;
      S_WAIT_CALC: if (i_core_finished) state_next = S_SEND_DATA;
      S_SEND_DATA: if (last) state_next = S_GET_DATA;
      default:     state_next = S_GET_N;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      n     <= '0;
      e     <= '0;
      a     <= '0;
      res   <= '0;
      cnt   <= '0;
      start <= 1'b0;
    end else begin
      start <= (state != S_WAIT_CALC) &&
               (state_next == S_WAIT_CALC);
      // cnt wraps to 0 exactly when the state changes
      if (done) cnt <= last ? 5'd0 : cnt + 5'd1;
      unique case (state)
        S_GET_N:     if (done) n <= {n[247:0], rx_byte};
        S_GET_E:     if (done) e <= {e[247:0], rx_byte};
        S_GET_DATA:  if (done) a <= {a[247:0], rx_byte};
        S_WAIT_CALC: if (i_core_finished) res <= i_core_result[247:0];
        S_SEND_DATA: if (done) res <= {res[239:0], 8'd0};
        default: ;
      endcase
    end
  end

endmodule
